// File: rtl/and_64bit_pkg.sv
// Shared execute-stage ALU package: condition-flag layout used by every
// unit that produces a cf_* vector, plus a helper that packs the flags.
package and_64bit_pkg;

    localparam int FLAG_W = 3;
    localparam int ZF_BIT = 0;
    localparam int SF_BIT = 1;
    localparam int OF_BIT = 2;

    // Flags presented on an idle cycle when outputs are not held: result 0, ZF set.
    localparam logic [FLAG_W-1:0] FLAGS_IDLE = 3'b001;

    // Pack zero/sign information into the shared flag layout; AND never overflows.
    function automatic logic [FLAG_W-1:0] pack_flags(input logic zero, input logic msb);
        logic [FLAG_W-1:0] f;
        f         = '0;
        f[ZF_BIT] = zero;
        f[SF_BIT] = msb;
        f[OF_BIT] = 1'b0;
        return f;
    endfunction

endpackage

// File: rtl/and_64bit_and_1bit.sv
// Single-bit AND cell, replicated across the operand width by and_64bit.
module and_1bit (
    input  logic a,
    input  logic b,
    output logic out
);

    assign out = a & b;

endmodule

// File: rtl/and_64bit.sv
// and_64bit: registered bitwise AND with condition flags and one-cycle latency.
// Optional build macro AND_64BIT_HOLD_EN: when defined, out/cf_and keep their
// last values on idle cycles; otherwise they load 0 / ZF-only flags.
// Reset is synchronous and active-low; it overrides any valid input.
module and_64bit
    import and_64bit_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] out,
    output logic [FLAG_W-1:0]       cf_and,
    output logic                    out_valid
);

    logic [WIDTH-1:0]  and_s;
    logic [WIDTH-1:0]  next_out_s;
    logic [FLAG_W-1:0] next_flags_s;

    // One AND cell per bit; signedness of the operands plays no part here.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        and_1bit u_and_1bit (
            .a   (a[i]),
            .b   (b[i]),
            .out (and_s[i])
        );
    end

    // Select the value the output registers load this cycle (new result or idle value).
    always_comb begin
        next_out_s   = '0;
        next_flags_s = FLAGS_IDLE;
        if (in_valid) begin
            next_out_s   = and_s;
            next_flags_s = pack_flags((and_s == '0), and_s[WIDTH-1]);
        end else begin
`ifdef AND_64BIT_HOLD_EN
            next_out_s   = out;
            next_flags_s = cf_and;
`else
            next_out_s   = '0;
            next_flags_s = FLAGS_IDLE;
`endif
        end
    end

    // Output registers; reset wins over a same-cycle valid and drops any in-flight result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out       <= '0;
            cf_and    <= '0;
            out_valid <= 1'b0;
        end else begin
            out       <= next_out_s;
            cf_and    <= next_flags_s;
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_and_64bit.sv
// Self-checking bench for and_64bit: directed literal cases plus randomized
// stimulus compared every cycle against a behavioural model.
module tb_and_64bit;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic signed [63:0] a;
    logic signed [63:0] b;
    logic signed [63:0] out;
    logic [2:0]         cf_and;
    logic               out_valid;

    // Behavioural expectation for the outputs after the most recent edge
    logic [63:0] m_out;
    logic [2:0]  m_flags;
    logic        m_valid;
    logic        checking;

    int n_cmp;
    int n_bad;

    and_64bit #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out       (out),
        .cf_and    (cf_and),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: what the spec says the outputs must be after this edge
    always @(posedge clk) begin
        if (!rst_n) begin
            m_out   = 64'd0;
            m_flags = 3'b000;
            m_valid = 1'b0;
        end else if (in_valid) begin
            m_out   = a & b;
            m_flags = {1'b0, ($signed(m_out) < 64'sd0), (m_out == 64'd0)};
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
`ifndef AND_64BIT_HOLD_EN
            m_out   = 64'd0;
            m_flags = 3'b001;
`endif
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (checking) begin
            n_cmp++;
            if (out !== m_out || cf_and !== m_flags || out_valid !== m_valid) begin
                n_bad++;
                $display("FAIL model t=%0t: out=%h cf=%b v=%b expected out=%h cf=%b v=%b",
                         $time, out, cf_and, out_valid, m_out, m_flags, m_valid);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got_o, input logic [2:0] got_f,
                       input logic got_v, input logic [63:0] exp_o, input logic [2:0] exp_f,
                       input logic exp_v);
        n_cmp++;
        if (got_o !== exp_o || got_f !== exp_f || got_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s: out=%h cf=%b v=%b expected out=%h cf=%b v=%b",
                     name, got_o, got_f, got_v, exp_o, exp_f, exp_v);
        end
    endtask

    // Apply one cycle of inputs, return at the following falling edge
    task automatic step(input logic [63:0] ta, input logic [63:0] tb, input logic tv,
                        input logic tr);
        a        = ta;
        b        = tb;
        in_valid = tv;
        rst_n    = tr;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        checking = 1'b0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        @(negedge clk);

        // Reset held two cycles, with a valid pair present to show reset priority
        step(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        step(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        chk("reset", out, cf_and, out_valid, 64'd0, 3'b000, 1'b0);
        checking = 1'b1;

        step(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        chk("all_ones", out, cf_and, out_valid, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010, 1'b1);

        step(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b1);
        chk("neg_mask", out, cf_and, out_valid, 64'hFFFF_FFFF_FFFF_FFFC, 3'b010, 1'b1);

        step(64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_0000_0000, 1'b1, 1'b1);
        chk("zero_res", out, cf_and, out_valid, 64'd0, 3'b001, 1'b1);

        step(64'h7FFF_FFFF_FFFF_FFFF, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1, 1'b1);
        chk("pos_res", out, cf_and, out_valid, 64'h0F0F_0F0F_0F0F_0F0F, 3'b000, 1'b1);

        step(64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
`ifdef AND_64BIT_HOLD_EN
        chk("idle_hold", out, cf_and, out_valid, 64'h0F0F_0F0F_0F0F_0F0F, 3'b000, 1'b0);
`else
        chk("idle_zero", out, cf_and, out_valid, 64'd0, 3'b001, 1'b0);
`endif

        // Back-to-back stream, then reset mid-stream
        step(64'h8000_0000_0000_0001, 64'h8000_0000_0000_0003, 1'b1, 1'b1);
        chk("b2b_0", out, cf_and, out_valid, 64'h8000_0000_0000_0001, 3'b010, 1'b1);
        step(64'h00FF_00FF_00FF_00FF, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1, 1'b1);
        chk("b2b_1", out, cf_and, out_valid, 64'h000F_000F_000F_000F, 3'b000, 1'b1);
        step(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 1'b1);
        chk("b2b_2", out, cf_and, out_valid, 64'd0, 3'b001, 1'b1);
        step(64'hF000_0000_0000_0000, 64'hC000_0000_0000_0000, 1'b1, 1'b1);
        chk("b2b_3", out, cf_and, out_valid, 64'hC000_0000_0000_0000, 3'b010, 1'b1);
        step(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        chk("mid_reset", out, cf_and, out_valid, 64'd0, 3'b000, 1'b0);

        // First valid after release appears exactly one cycle later
        step(64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 1'b1, 1'b1);
        chk("post_reset", out, cf_and, out_valid, 64'd1, 3'b000, 1'b1);

        // Randomized traffic with sparse valids and occasional resets
        for (int i = 0; i < 400; i++) begin
            logic [63:0] ra;
            logic [63:0] rb;
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            case ($urandom_range(0, 7))
                0: rb = ~ra;
                1: rb = 64'hFFFF_FFFF_FFFF_FFFF;
                2: ra = ra | 64'h8000_0000_0000_0000;
                default: ;
            endcase
            step(ra, rb, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) != 0));
        end

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/and_64bit.md
AND_64BIT -- requirements
Module: and_64bit

Interface
REQ-001 Parameter WIDTH, default 64, operand/result width; the block SHALL be verified at 64 only.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 in_valid  input  1  operands a/b are valid this cycle.
REQ-005 a  input  WIDTH (signed)  first operand.
REQ-006 b  input  WIDTH (signed)  second operand.
REQ-007 out  output  WIDTH (signed)  registered bitwise AND result.
REQ-008 cf_and  output  3  registered condition flags: [0]=ZF, [1]=SF, [2]=OF.
REQ-009 out_valid  output  1  out/cf_and hold a result produced from a valid input.

Function
REQ-010 On a rising clk with rst_n=1 and in_valid=1, out SHALL become a & b, bit for bit.
REQ-011 Latency SHALL be exactly one cycle; out_valid SHALL equal in_valid delayed by one cycle.
REQ-012 ZF SHALL be 1 iff the new result is all zeros.
REQ-013 SF SHALL equal bit WIDTH-1 of the new result.
REQ-014 OF SHALL always be 0, since AND cannot overflow.
REQ-015 No back-pressure; a new operand pair SHALL be accepted every cycle with no stall.
REQ-016 When in_valid=0, out_valid SHALL be 0 next cycle; out/cf_and follow REQ-024.
REQ-017 Operand signedness SHALL NOT affect out; it affects SF only through the MSB.

Reset
REQ-018 While rst_n=0 at a rising clk: out = 0, cf_and = 3'b000, out_valid = 0.
REQ-019 Reset SHALL take priority over in_valid in the same cycle.
REQ-020 An operation in flight when reset is asserted SHALL be discarded, not presented.
REQ-021 The first valid result after reset release SHALL appear one cycle after the first in_valid=1 edge.

Configuration
REQ-022 Macro AND_64BIT_HOLD_EN selects idle-cycle behaviour.
REQ-023 With AND_64BIT_HOLD_EN defined, out and cf_and SHALL hold their last values when in_valid=0.
REQ-024 Without AND_64BIT_HOLD_EN, out SHALL load 0 and cf_and SHALL load 3'b001 (ZF=1) when in_valid=0.

Structure
REQ-025 Flag bit indices (ZF_BIT=0, SF_BIT=1, OF_BIT=2) and the flag width (3) SHALL live in the shared ALU package, shared with the other execute-stage units.
REQ-026 The per-bit AND SHALL be a sub-module and_1bit (inputs a, b; output out), instantiated WIDTH times through a generate loop.
REQ-027 Flag generation and output registers SHALL be in and_64bit itself.

Verification
REQ-028 Reset with rst_n=0 for 2 cycles, then release -> out=0, cf_and=000, out_valid=0.
REQ-029 a=0xFFFFFFFFFFFFFFFF, b=0xFFFFFFFFFFFFFFFF, in_valid=1 -> next cycle out=0xFFFFFFFFFFFFFFFF, cf_and=010, out_valid=1.
REQ-030 a=0xFFFFFFFFFFFFFFFE, b=0xFFFFFFFFFFFFFFFC -> out=0xFFFFFFFFFFFFFFFC, cf_and=010.
REQ-031 a=0x00000000FFFFFFFF, b=0xFFFFFFFF00000000 -> out=0, cf_and=001.
REQ-032 a=0x7FFFFFFFFFFFFFFF, b=0x0F0F0F0F0F0F0F0F, then in_valid=0 -> out=0x0F0F0F0F0F0F0F0F, cf_and=000; next cycle out_valid=0, out held with the macro, 0/cf_and=001 without.
REQ-033 Back-to-back valid pairs for 4 cycles, then rst_n=0 mid-stream -> each result appears exactly one cycle after its inputs; the cycle after reset shows all zeros and out_valid=0.
